uart_tx_arbiter: RTL and testbench

Owns the UART transmit channel (board -> GenshinKitchen) and shares it between two byte requesters: the manual-control encoder and the script executor. The UART transmits its input byte continuously and pulses uart_ready after each byte completes. This block presents IDLE_BYTE between commands and guarantees that each granted command byte is transmitted exactly once, whole. It acknowledges the winning requester only after that byte has fully left the UART. It sits between the requesters and the UART io_dataIn port.

---
 rtl/tx_pkg.sv | 16 +
 rtl/tx_watchdog.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 133 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, the idle
// filler byte and the bit positions inside the one-hot grant vector.
package tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    SEND  = 2'd2
  } tx_state_t;

  localparam logic [7:0] IDLE_BYTE = 8'h00;

  localparam int GRANT_MAN = 0;
  localparam int GRANT_AUT = 1;

endpackage

// File: rtl/tx_watchdog.sv
// Saturating cycle counter that flags a stalled transfer once it has counted
// LIMIT-1 cycles without being cleared.
module tx_watchdog #(
  parameter int              TO_W  = 16,
  parameter logic [TO_W-1:0] LIMIT = 16'd8192
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = LIMIT - TO_W'(1);

  logic [TO_W-1:0] count;

  // Clear has priority; the count parks at all-ones instead of wrapping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + TO_W'(1);
    end
  end

  assign expired = (count >= LAST);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the UART transmit byte between the manual encoder and the script
// executor, keeping IDLE_BYTE on the line between single-byte commands.
module uart_tx_arbiter
  import tx_pkg::*;
#(
  parameter int              TO_W           = 16,
  parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 16'd8192
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode_auto,
  input  logic       man_valid,
  input  logic [7:0] man_bits,
  output logic       man_ack,
  input  logic       aut_valid,
  input  logic [7:0] aut_bits,
  output logic       aut_ack,
  input  logic       uart_ready,
  output logic [7:0] uart_bits,
  output logic       busy,
  output logic [1:0] grant,
  output logic       timeout_err,
  input  logic       err_clr
);

  tx_state_t  state, state_n;
  logic [7:0] hold, hold_n;
  logic [7:0] bits_n;
  logic [1:0] grant_n;
  logic       man_ack_n, aut_ack_n, err_n;
  logic       wd_clear, wd_en, wd_expired;
  logic       pick_aut;

  tx_watchdog #(
    .TO_W  (TO_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_n   = state;
    hold_n    = hold;
    bits_n    = uart_bits;
    grant_n   = grant;
    man_ack_n = 1'b0;
    aut_ack_n = 1'b0;
    err_n     = err_clr ? 1'b0 : timeout_err;
    wd_clear  = uart_ready;
    wd_en     = 1'b0;
    pick_aut  = 1'b0;

    unique case (state)
      IDLE: begin
        bits_n  = IDLE_BYTE;
        grant_n = 2'b00;
        // Nothing is granted in the ack cycle, so a valid still held there
        // cannot buy a second byte for the same handshake.
        if (!(man_ack || aut_ack) && (man_valid || aut_valid)) begin
          pick_aut = aut_valid && (mode_auto || !man_valid);
          hold_n   = pick_aut ? aut_bits : man_bits;
          bits_n   = hold_n;
          grant_n  = pick_aut ? 2'b10 : 2'b01;
          wd_clear = 1'b1;
          state_n  = ALIGN;
        end
      end

      ALIGN: begin
        wd_en  = 1'b1;
        bits_n = hold;
        if (uart_ready) begin
          state_n = SEND;
        end else if (wd_expired) begin
          err_n   = 1'b1;
          grant_n = 2'b00;
          bits_n  = IDLE_BYTE;
          state_n = IDLE;
        end
      end

      SEND: begin
        wd_en  = 1'b1;
        bits_n = hold;
        if (uart_ready) begin
          man_ack_n = grant[GRANT_MAN];
          aut_ack_n = grant[GRANT_AUT];
          grant_n   = 2'b00;
          bits_n    = IDLE_BYTE;
          state_n   = IDLE;
        end else if (wd_expired) begin
          err_n   = 1'b1;
          grant_n = 2'b00;
          bits_n  = IDLE_BYTE;
          state_n = IDLE;
        end
      end

      default: begin
        grant_n = 2'b00;
        bits_n  = IDLE_BYTE;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      hold        <= IDLE_BYTE;
      uart_bits   <= IDLE_BYTE;
      grant       <= 2'b00;
      busy        <= 1'b0;
      man_ack     <= 1'b0;
      aut_ack     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      hold        <= hold_n;
      uart_bits   <= bits_n;
      grant       <= grant_n;
      busy        <= (state_n != IDLE);
      man_ack     <= man_ack_n;
      aut_ack     <= aut_ack_n;
      timeout_err <= err_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a vector table for single commands plus
// hand-written sequences for ordering, pre-emption, latching, reset and abort.
module tb_uart_tx_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       mode_auto = 1'b0;
  logic       man_valid = 1'b0;
  logic [7:0] man_bits = 8'h00;
  logic       aut_valid = 1'b0;
  logic [7:0] aut_bits = 8'h00;
  logic       uart_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic       man_ack, aut_ack, busy, timeout_err;
  logic [7:0] uart_bits;
  logic [1:0] grant;

  int checkCount = 0;
  int passCount  = 0;
  int ackCount   = 0;
  bit bothAcks   = 1'b0;

  typedef struct {
    logic       mode;
    logic       mv;
    logic [7:0] mb;
    logic       av;
    logic [7:0] ab;
    logic [1:0] expGrant;
    logic [7:0] expByte;
  } vec_t;

  vec_t vecs[6];

  uart_tx_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .mode_auto   (mode_auto),
    .man_valid   (man_valid),
    .man_bits    (man_bits),
    .man_ack     (man_ack),
    .aut_valid   (aut_valid),
    .aut_bits    (aut_bits),
    .aut_ack     (aut_ack),
    .uart_ready  (uart_ready),
    .uart_bits   (uart_bits),
    .busy        (busy),
    .grant       (grant),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (man_ack && aut_ack) bothAcks = 1'b1;
    if (man_ack || aut_ack) ackCount++;
  end

  initial begin
    #1500000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic m, input logic mv, input logic [7:0] mb,
                               input logic av, input logic [7:0] ab);
    mode_auto = m;
    man_valid = mv;
    man_bits  = mb;
    aut_valid = av;
    aut_bits  = ab;
  endtask

  task automatic pulseReady();
    uart_ready = 1'b1;
    step();
    uart_ready = 1'b0;
  endtask

  task automatic waitGrant(input string name);
    int n;
    n = 0;
    while (grant == 2'b00 && n < 20) begin
      step();
      n++;
    end
    if (grant == 2'b00) checkOutput({name, "_grant_wait"}, 16'(n), 16'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 8'h2C, 1'b0, 8'h00, 2'b01, 8'h2C};
    vecs[1] = '{1'b1, 1'b1, 8'h2C, 1'b0, 8'h00, 2'b01, 8'h2C};
    vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h55, 2'b10, 8'h55};
    vecs[3] = '{1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 2'b10, 8'h22};
    vecs[4] = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 2'b01, 8'h11};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hA5, 2'b10, 8'hA5};

    // Reset values.
    step();
    step();
    checkOutput("rst_bits", 16'(uart_bits), 16'h00);
    checkOutput("rst_grant", 16'(grant), 16'h0);
    checkOutput("rst_busy", 16'(busy), 16'h0);
    checkOutput("rst_acks", 16'({man_ack, aut_ack}), 16'h0);
    checkOutput("rst_err", 16'(timeout_err), 16'h0);
    reset = 1'b1;
    step();

    // Single-command vectors.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].mv, vecs[i].mb, vecs[i].av, vecs[i].ab);
      step();
      checkOutput("vec_grant", 16'(grant), 16'(vecs[i].expGrant));
      checkOutput("vec_bits_align", 16'(uart_bits), 16'(vecs[i].expByte));
      checkOutput("vec_busy", 16'(busy), 16'h1);
      pulseReady();
      checkOutput("vec_bits_send", 16'(uart_bits), 16'(vecs[i].expByte));
      checkOutput("vec_no_early_ack", 16'({aut_ack, man_ack}), 16'h0);
      pulseReady();
      checkOutput("vec_ack", 16'({aut_ack, man_ack}), 16'(vecs[i].expGrant));
      checkOutput("vec_grant_clr", 16'(grant), 16'h0);
      checkOutput("vec_bits_idle", 16'(uart_bits), 16'h00);
      checkOutput("vec_busy_clr", 16'(busy), 16'h0);
      step();
      checkOutput("vec_ack_pulse", 16'({aut_ack, man_ack}), 16'h0);
      checkOutput("vec_no_regrant", 16'(grant & vecs[i].expGrant), 16'h0);
      applyStimulus(vecs[i].mode, 1'b0, 8'h00, 1'b0, 8'h00);
      step();
      step();
    end

    // Manual byte with uart_ready every 160 cycles; bits change after grant.
    begin
      int bad;
      int acksBefore;
      bad = 0;
      applyStimulus(1'b0, 1'b1, 8'h2C, 1'b0, 8'h00);
      step();
      man_bits = 8'h3D;
      acksBefore = ackCount;
      for (int p = 0; p < 2; p++) begin
        for (int c = 0; c < 159; c++) begin
          if (uart_bits != 8'h2C) bad++;
          step();
        end
        if (uart_bits != 8'h2C) bad++;
        uart_ready = 1'b1;
        step();
        uart_ready = 1'b0;
      end
      checkOutput("slow_bits_held", 16'(bad), 16'h0);
      checkOutput("slow_man_ack", 16'(man_ack), 16'h1);
      checkOutput("slow_acks_once", 16'(ackCount - acksBefore), 16'h0);
      man_valid = 1'b0;
      step();
      checkOutput("slow_ack_single", 16'(man_ack), 16'h0);
      checkOutput("slow_bits_idle", 16'(uart_bits), 16'h00);
      checkOutput("slow_ack_total", 16'(ackCount - acksBefore), 16'h1);
    end

    // uart_ready coincident with the grant does not count as alignment.
    applyStimulus(1'b0, 1'b1, 8'h47, 1'b0, 8'h00);
    uart_ready = 1'b1;
    step();
    uart_ready = 1'b0;
    pulseReady();
    checkOutput("coinc_no_ack", 16'(man_ack), 16'h0);
    pulseReady();
    checkOutput("coinc_ack", 16'(man_ack), 16'h1);
    man_valid = 1'b0;
    step();

    // Both valid: winner order follows mode_auto, idle byte in between.
    for (int m = 0; m < 2; m++) begin
      applyStimulus(m[0], 1'b1, 8'h11, 1'b1, 8'h22);
      step();
      checkOutput("order_first_bits", 16'(uart_bits), m[0] ? 16'h22 : 16'h11);
      pulseReady();
      pulseReady();
      checkOutput("order_first_ack", 16'({aut_ack, man_ack}), m[0] ? 16'h2 : 16'h1);
      checkOutput("order_gap_idle", 16'(uart_bits), 16'h00);
      if (m[0]) aut_valid = 1'b0;
      else man_valid = 1'b0;
      waitGrant("order");
      checkOutput("order_second_bits", 16'(uart_bits), m[0] ? 16'h11 : 16'h22);
      pulseReady();
      pulseReady();
      checkOutput("order_second_ack", 16'({aut_ack, man_ack}), m[0] ? 16'h1 : 16'h2);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      step();
      step();
    end

    // mode_auto toggled while the auto byte is in SEND.
    applyStimulus(1'b1, 1'b1, 8'h11, 1'b1, 8'h22);
    step();
    pulseReady();
    mode_auto = 1'b0;
    step();
    checkOutput("toggle_keep_grant", 16'(grant), 16'h2);
    checkOutput("toggle_keep_bits", 16'(uart_bits), 16'h22);
    pulseReady();
    checkOutput("toggle_aut_ack", 16'({aut_ack, man_ack}), 16'h2);
    aut_valid = 1'b0;
    step();
    aut_valid = 1'b1;
    aut_bits  = 8'h33;
    waitGrant("toggle");
    checkOutput("toggle_new_prio", 16'(grant), 16'h1);
    checkOutput("toggle_new_bits", 16'(uart_bits), 16'h11);
    pulseReady();
    pulseReady();
    checkOutput("toggle_man_ack", 16'(man_ack), 16'h1);
    man_valid = 1'b0;
    waitGrant("toggle_aut");
    checkOutput("toggle_aut_bits", 16'(uart_bits), 16'h33);
    pulseReady();
    pulseReady();
    checkOutput("toggle_aut_ack2", 16'(aut_ack), 16'h1);
    aut_valid = 1'b0;
    step();
    step();

    // Reset asserted mid-SEND drops the command.
    begin
      int acksBefore;
      applyStimulus(1'b0, 1'b1, 8'h2C, 1'b0, 8'h00);
      step();
      pulseReady();
      #2;
      reset = 1'b0;
      #1;
      checkOutput("midrst_bits", 16'(uart_bits), 16'h00);
      checkOutput("midrst_grant", 16'(grant), 16'h0);
      checkOutput("midrst_busy", 16'(busy), 16'h0);
      man_valid = 1'b0;
      acksBefore = ackCount;
      step();
      reset = 1'b1;
      pulseReady();
      step();
      pulseReady();
      step();
      checkOutput("midrst_no_ack", 16'(ackCount - acksBefore), 16'h0);
      applyStimulus(1'b0, 1'b1, 8'h5A, 1'b0, 8'h00);
      waitGrant("midrst");
      checkOutput("midrst_new_bits", 16'(uart_bits), 16'h5A);
      pulseReady();
      pulseReady();
      checkOutput("midrst_new_ack", 16'(man_ack), 16'h1);
      man_valid = 1'b0;
      step();
      step();
    end

    // Watchdog abort, retry, err_clr, and err_clr coincident with abort.
    begin
      int n;
      int acksBefore;
      applyStimulus(1'b0, 1'b1, 8'h66, 1'b0, 8'h00);
      step();
      acksBefore = ackCount;
      n = 0;
      while (!timeout_err && n < 9000) begin
        step();
        n++;
      end
      checkOutput("to_cycles", 16'(n), 16'd8192);
      checkOutput("to_grant_clr", 16'(grant), 16'h0);
      checkOutput("to_bits_idle", 16'(uart_bits), 16'h00);
      checkOutput("to_no_ack", 16'(ackCount - acksBefore), 16'h0);
      step();
      checkOutput("to_regrant", 16'(grant), 16'h1);
      checkOutput("to_err_sticky", 16'(timeout_err), 16'h1);
      err_clr = 1'b1;
      step();
      checkOutput("to_err_clr", 16'(timeout_err), 16'h0);
      n = 0;
      while (grant != 2'b00 && n < 9000) begin
        step();
        n++;
      end
      checkOutput("to_abort_wins", 16'(timeout_err), 16'h1);
      checkOutput("to_no_ack2", 16'(ackCount - acksBefore), 16'h0);
      err_clr = 1'b0;
      man_valid = 1'b0;
      step();
      step();
      checkOutput("to_idle_after", 16'(grant), 16'h0);
    end

    checkOutput("acks_exclusive", 16'(bothAcks), 16'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
